// File: rtl/cntr_snap_serializer.sv
// Snapshots a packed counter vector and streams it out LSB nibble first over valid/ready.
// Optional SNAP_CHANGE_FILTER_EN: skip idle requests whose data matches the last captured vector.
module cntr_snap_serializer #(
  parameter  int NIB_CNT = 8,
  parameter  int NIB_W   = 4,
  localparam int IW      = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     snap_req,
  input  logic [NIB_CNT*NIB_W-1:0] data_in,
  output logic                     busy,
  output logic                     nib_valid,
  input  logic                     nib_ready,
  output logic [NIB_W-1:0]         nib_data,
  output logic [IW-1:0]            nib_idx,
  output logic                     nib_last,
  output logic [7:0]               ovr_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state, state_nxt;
  logic [NIB_CNT-1:0][NIB_W-1:0]  shadow;
  logic [IW-1:0]                  idx;
  logic                           at_last, xfer, slot, pass, cap, drop;

`ifdef SNAP_CHANGE_FILTER_EN
  logic [NIB_CNT*NIB_W-1:0] last_sent;
  logic                     first;
  assign pass = first | (data_in != last_sent);
`else
  assign pass = 1'b1;
`endif

  assign at_last = (idx == IW'(NIB_CNT-1));
  assign xfer    = (state == SEND) & nib_ready;
  // a capture slot exists in IDLE or on the edge that retires the last nibble
  assign slot    = (state == IDLE) | (xfer & at_last);
  assign cap     = snap_req & slot & pass;
  assign drop    = snap_req & (state == SEND) & ~(xfer & at_last);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cap) state_nxt = SEND;
      SEND: begin
        if (cap)                  state_nxt = SEND;
        else if (xfer && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      ovr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        shadow <= data_in;
        idx    <= '0;
      end else if (xfer) begin
        idx <= at_last ? '0 : idx + IW'(1);
      end
      if (drop && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

`ifdef SNAP_CHANGE_FILTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_sent <= '0;
      first     <= 1'b1;
    end else if (cap) begin
      last_sent <= data_in;
      first     <= 1'b0;
    end
  end
`endif

  assign busy      = (state == SEND);
  assign nib_valid = busy;
  assign nib_data  = busy ? shadow[idx] : '0;
  assign nib_idx   = idx;
  assign nib_last  = busy & at_last;

endmodule

// File: tb/tb_cntr_snap_serializer.sv
// Directed bench for cntr_snap_serializer: stream order, backpressure, overrun, back-to-back, reset.
module tb_cntr_snap_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        snap_req = 1'b0;
  logic [31:0] data_in = '0;
  logic        busy, nib_valid, nib_last;
  logic        nib_ready = 1'b0;
  logic [3:0]  nib_data;
  logic [2:0]  nib_idx;
  logic [7:0]  ovr_cnt;

  int total = 0;
  int fails = 0;

  cntr_snap_serializer #(.NIB_CNT(8), .NIB_W(4)) dut (
    .clk(clk), .reset(reset), .snap_req(snap_req), .data_in(data_in),
    .busy(busy), .nib_valid(nib_valid), .nib_ready(nib_ready),
    .nib_data(nib_data), .nib_idx(nib_idx), .nib_last(nib_last), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    snap_req = 1'b0;
    #1;
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    int e;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", nib_valid, 0);
    chk("rst_data", nib_data, 0);
    chk("rst_idx", nib_idx, 0);
    chk("rst_last", nib_last, 0);
    chk("rst_ovr", ovr_cnt, 0);
    step();
    reset = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // full-rate stream
    data_in = 32'h87654321; nib_ready = 1'b1; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", nib_valid, 1);
      chk("t1_idx", nib_idx, k);
      chk("t1_data", nib_data, k + 1);
      chk("t1_last", nib_last, (k == 7));
      step();
    end
    chk("t1_busy_after", busy, 0);
    chk("t1_valid_after", nib_valid, 0);
    chk("t1_ovr", ovr_cnt, 0);

    // backpressure 1,0,0,1,0,0,...
    do_reset();
    data_in = 32'h87654321; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    data_in = 32'hFFFFFFFF;
    e = 0;
    for (int c = 0; c < 60 && e < 8; c++) begin
      nib_ready = (c % 3 == 0);
      chk("t2_valid", nib_valid, 1);
      chk("t2_idx", nib_idx, e);
      chk("t2_data", nib_data, e + 1);
      chk("t2_last", nib_last, (e == 7));
      step();
      if (nib_ready) e++;
    end
    chk("t2_done", e, 8);
    chk("t2_busy_after", busy, 0);
    nib_ready = 1'b1;

    // request on the last-nibble transfer edge
    do_reset();
    data_in = 32'h87654321; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("t4_at_last", nib_last, 1);
    data_in = 32'hAAAAAAAA; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("t4_valid", nib_valid, 1);
    chk("t4_idx", nib_idx, 0);
    chk("t4_data", nib_data, 4'hA);
    chk("t4_ovr", ovr_cnt, 0);
    for (int k = 0; k < 8; k++) begin
      chk("t4_stream", nib_data, 4'hA);
      step();
    end
    chk("t4_busy_after", busy, 0);

    // overrun counting and saturation
    do_reset();
    data_in = 32'h87654321; snap_req = 1'b1;
    step();
    nib_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    snap_req = 1'b0;
    step();
    chk("t3_ovr3", ovr_cnt, 3);
    chk("t3_held_idx", nib_idx, 0);
    snap_req = 1'b1;
    for (int k = 0; k < 300; k++) step();
    snap_req = 1'b0;
    chk("t3_ovr_sat", ovr_cnt, 255);
    nib_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("t3_busy_after", busy, 0);

    // reset mid-send
    data_in = 32'h87654321; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("t5_pre_idx", nib_idx, 4);
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", nib_valid, 0);
    chk("t5_data", nib_data, 0);
    chk("t5_idx", nib_idx, 0);
    chk("t5_last", nib_last, 0);
    chk("t5_ovr", ovr_cnt, 0);
    step();
    chk("t5_valid_held", nib_valid, 0);
    reset = 1'b1;
    step();
    chk("t5_idle", busy, 0);
    data_in = 32'h12345678; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("t5_new_valid", nib_valid, 1);
    chk("t5_new_idx", nib_idx, 0);
    chk("t5_new_data", nib_data, 8);
    for (int k = 0; k < 8; k++) step();

    // identical-data requests after reset
    do_reset();
    data_in = 32'h0; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("f_first_sent", busy, 1);
    for (int k = 0; k < 8; k++) step();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
`ifdef SNAP_CHANGE_FILTER_EN
    chk("f_repeat_ignored", busy, 0);
    chk("f_repeat_ovr", ovr_cnt, 0);
`else
    chk("f_repeat_sent", busy, 1);
    for (int k = 0; k < 8; k++) step();
`endif
    data_in = 32'h5; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("f_changed_sent", busy, 1);
    chk("f_changed_data", nib_data, 5);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
